// File: rtl/gray_seq_checker.sv
// rtl/gray_seq_checker.sv - checks a sampled Gray-code stream for single legal forward steps
// Tracks lock state and counts illegal transitions with a saturating counter.
module gray_seq_checker #(
  parameter int WIDTH  = 3,
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             step,
  output logic             wrap,
  output logic             err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [GW-1:0] LOCK_V = GW'(LOCK_N);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     good_q, good_d;
  logic [WIDTH-1:0]  bin_d;
  logic              step_d, wrap_d, err_d;
  logic [ERR_W-1:0]  err_cnt_d;

  logic [WIDTH-1:0]  gray_bin;
  logic [WIDTH-1:0]  bin_inc;
  logic [WIDTH-1:0]  exp_gray;
  logic [WIDTH-1:0]  ref_gray;
  logic [GW-1:0]     good_inc;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // The reference is held in binary form; its Gray image is recomputed for the hold compare.
  assign gray_bin = gray2bin(gray);
  assign bin_inc  = bin + 1'b1;
  assign exp_gray = bin_inc ^ (bin_inc >> 1);
  assign ref_gray = bin ^ (bin >> 1);
  assign good_inc = (good_q == LOCK_V) ? good_q : good_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    bin_d     = bin;
    err_cnt_d = err_cnt;
    step_d    = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    if (en) begin
      if (state_q == S_EMPTY) begin
        bin_d   = gray_bin;
        good_d  = '0;
        state_d = S_ACQUIRE;
      end else if (gray == ref_gray) begin
        state_d = state_q;
      end else if (gray == exp_gray) begin
        bin_d  = gray_bin;
        step_d = 1'b1;
        wrap_d = (bin == {WIDTH{1'b1}});
        good_d = good_inc;
        if (good_inc == LOCK_V) begin
          state_d = S_LOCKED;
        end
      end else begin
        err_d     = 1'b1;
        err_cnt_d = (&err_cnt) ? err_cnt : err_cnt + 1'b1;
        bin_d     = gray_bin;
        good_d    = '0;
        state_d   = S_ACQUIRE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      good_q  <= '0;
      bin     <= '0;
      step    <= 1'b0;
      wrap    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bin     <= bin_d;
      step    <= step_d;
      wrap    <= wrap_d;
      err     <= err_d;
      err_cnt <= err_cnt_d;
    end
  end

  assign locked = (state_q == S_LOCKED);

endmodule

// File: tb/tb_gray_seq_checker.sv
// tb/tb_gray_seq_checker.sv - self-checking bench for gray_seq_checker
// Directed vector table, hand-written corner sequences, and random stimulus against a reference model.
module tb_gray_seq_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] gray;
  logic [2:0] bin, bin_s;
  logic       step, wrap, err, locked;
  logic       step_s, wrap_s, err_s, locked_s;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_s;

  int n_cmp;
  int n_bad;

  gray_seq_checker #(.WIDTH(3), .LOCK_N(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .gray(gray), .bin(bin), .step(step),
    .wrap(wrap), .err(err), .locked(locked), .err_cnt(err_cnt)
  );

  gray_seq_checker #(.WIDTH(3), .LOCK_N(4), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .gray(gray), .bin(bin_s), .step(step_s),
    .wrap(wrap_s), .err(err_s), .locked(locked_s), .err_cnt(err_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] g;
    logic [2:0] b;
    logic       s, w, e, l;
    int         ec;
  } vec_t;

  vec_t tbl[$];

  // Reference model: position is an index into the Gray sequence, not a bit-level state.
  int m_valid, m_pos, m_good, m_locked, m_ec, m_step, m_wrap, m_err;

  function automatic int gray_index(input int g);
    for (int i = 0; i < 8; i++) begin
      if ((i ^ (i >> 1)) == g) return i;
    end
    return -1;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_pos = 0; m_good = 0; m_locked = 0; m_ec = 0;
    m_step = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_step(input int e, input int g);
    int idx;
    m_step = 0; m_wrap = 0; m_err = 0;
    if (e != 0) begin
      idx = gray_index(g);
      if (m_valid == 0) begin
        m_valid = 1; m_pos = idx; m_good = 0; m_locked = 0;
      end else if (idx == m_pos) begin
        m_step = 0;
      end else if (idx == (m_pos + 1) % 8) begin
        m_step = 1;
        m_wrap = (m_pos == 7) ? 1 : 0;
        m_pos  = idx;
        if (m_good < 4) m_good++;
        if (m_good == 4) m_locked = 1;
      end else begin
        m_err = 1; m_ec++; m_pos = idx; m_good = 0; m_locked = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".bin"}, bin, m_pos);
    chk({tag, ".step"}, step, m_step);
    chk({tag, ".wrap"}, wrap, m_wrap);
    chk({tag, ".err"}, err, m_err);
    chk({tag, ".locked"}, locked, m_locked);
    chk({tag, ".err_cnt"}, err_cnt, imin(m_ec, 255));
    chk({tag, ".err_cnt_sat"}, err_cnt_s, imin(m_ec, 3));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".bin"}, bin, 0);
    chk({tag, ".step"}, step, 0);
    chk({tag, ".wrap"}, wrap, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".locked"}, locked, 0);
    chk({tag, ".err_cnt"}, err_cnt, 0);
    chk({tag, ".err_cnt_sat"}, err_cnt_s, 0);
  endtask

  task automatic cycle(input logic e, input logic [2:0] g);
    en = e; gray = g;
    model_step(e, g);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; gray = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    model_reset();
  endtask

  task automatic add(input logic e, input logic [2:0] g, input logic [2:0] b,
                     input logic s, input logic w, input logic er, input logic l, input int ec);
    vec_t v;
    v.en = e; v.g = g; v.b = b; v.s = s; v.w = w; v.e = er; v.l = l; v.ec = ec;
    tbl.push_back(v);
  endtask

  initial begin
    logic [2:0] seq[6];
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; en = 1'b0; gray = 3'b000;
    model_reset();

    // Legal walk, hold/enable gaps, error from lock, skip and backward steps.
    add(1, 3'b000, 0, 0, 0, 0, 0, 0);
    add(1, 3'b001, 1, 1, 0, 0, 0, 0);
    add(1, 3'b011, 2, 1, 0, 0, 0, 0);
    add(1, 3'b010, 3, 1, 0, 0, 0, 0);
    add(1, 3'b110, 4, 1, 0, 0, 1, 0);
    add(1, 3'b111, 5, 1, 0, 0, 1, 0);
    add(1, 3'b101, 6, 1, 0, 0, 1, 0);
    add(1, 3'b100, 7, 1, 0, 0, 1, 0);
    add(1, 3'b000, 0, 1, 1, 0, 1, 0);
    add(1, 3'b001, 1, 1, 0, 0, 1, 0);
    add(1, 3'b011, 2, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 3'b011, 2, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 3'b010, 2, 0, 0, 0, 1, 0);
    add(1, 3'b010, 3, 1, 0, 0, 1, 0);
    add(1, 3'b110, 4, 1, 0, 0, 1, 0);
    add(1, 3'b111, 5, 1, 0, 0, 1, 0);
    add(1, 3'b101, 6, 1, 0, 0, 1, 0);
    add(1, 3'b110, 4, 0, 0, 1, 0, 1);
    add(1, 3'b111, 5, 1, 0, 0, 0, 1);
    add(1, 3'b001, 1, 0, 0, 1, 0, 2);
    add(1, 3'b010, 3, 0, 0, 1, 0, 3);
    add(1, 3'b011, 2, 0, 0, 1, 0, 4);

    do_reset();
    foreach (tbl[k]) begin
      cycle(tbl[k].en, tbl[k].g);
      chk($sformatf("tbl%0d.bin", k), bin, tbl[k].b);
      chk($sformatf("tbl%0d.step", k), step, tbl[k].s);
      chk($sformatf("tbl%0d.wrap", k), wrap, tbl[k].w);
      chk($sformatf("tbl%0d.err", k), err, tbl[k].e);
      chk($sformatf("tbl%0d.locked", k), locked, tbl[k].l);
      chk($sformatf("tbl%0d.err_cnt", k), err_cnt, tbl[k].ec);
      chk($sformatf("tbl%0d.err_cnt_sat", k), err_cnt_s, imin(tbl[k].ec, 3));
    end

    // Six consecutive errors on both counter widths.
    do_reset();
    cycle(1, 3'b000);
    for (int k = 0; k < 6; k++) begin
      cycle(1, (k % 2 == 0) ? 3'b011 : 3'b000);
      chk($sformatf("sat%0d.err", k), err, 1);
      chk($sformatf("sat%0d.err_cnt_sat", k), err_cnt_s, imin(k + 1, 3));
      chk($sformatf("sat%0d.err_cnt", k), err_cnt, k + 1);
      chk($sformatf("sat%0d.step", k), step, 0);
    end

    // Asynchronous reset while locked at bin=5, then first sample after release.
    do_reset();
    seq[0] = 3'b000; seq[1] = 3'b001; seq[2] = 3'b011;
    seq[3] = 3'b010; seq[4] = 3'b110; seq[5] = 3'b111;
    for (int k = 0; k < 6; k++) cycle(1, seq[k]);
    chk("pre_rst.bin", bin, 5);
    chk("pre_rst.locked", locked, 1);
    #2;
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    rst = 1'b1;
    model_reset();
    cycle(1, 3'b010);
    chk("post_rst.bin", bin, 3);
    chk("post_rst.step", step, 0);
    chk("post_rst.err", err, 0);
    chk("post_rst.locked", locked, 0);
    cycle(1, 3'b110);
    chk("acq.step", step, 1);
    chk("acq.bin", bin, 4);
    chk("acq.locked", locked, 0);

    // Random stimulus against the model, with occasional mid-cycle resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic e;
      logic [2:0] g;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        #2;
        rst = 1'b0;
        #1;
        check_zero("rnd_rst");
        rst = 1'b1;
        model_reset();
      end else begin
        e = ($urandom_range(0, 4) != 0);
        r = $urandom_range(0, 99);
        if (r < 60)      g = 3'(((m_pos + 1) % 8) ^ (((m_pos + 1) % 8) >> 1));
        else if (r < 75) g = 3'(m_pos ^ (m_pos >> 1));
        else             g = 3'($urandom_range(0, 7));
        cycle(e, g);
        check_model("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_seq_checker.md
# gray_seq_checker

Downstream consumer of the free-running Gray-code counter. Samples the counter's Gray output, converts it to binary, and checks that every change is exactly one legal forward step in the reflected-binary Gray sequence. Reports step, wrap and error pulses, a lock indication, and a saturating error count. Sits between the counter and any logic that needs a trusted binary position.

## Interface

- WIDTH, 3: Gray/binary width in bits.
- LOCK_N, 4: consecutive legal steps needed to assert `locked`.
- ERR_W, 8: width of the error counter.

- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately when 0.
- en  in  1  sample enable; `gray` is sampled only on edges where en=1.
- gray  in  WIDTH  Gray value from the counter.
- bin  out  WIDTH  binary equivalent of the current reference sample (registered).
- step  out  1  one-cycle pulse: legal forward step accepted.
- wrap  out  1  one-cycle pulse: legal step from binary 2^WIDTH-1 to 0.
- err  out  1  one-cycle pulse: illegal transition detected.
- locked  out  1  high after LOCK_N consecutive legal steps.
- err_cnt  out  ERR_W  errors since reset; saturates at 2^ERR_W-1.

## Operation

- Gray to binary conversion:
  - b[WIDTH-1] = g[WIDTH-1]
  - b[i] = b[i+1] ^ g[i]
- Expected next value: exp = bin2gray((ref_bin + 1) mod 2^WIDTH), where bin2gray(x) = x ^ (x>>1).
- State machine: EMPTY (reset state), ACQUIRE, LOCKED.
- en=1 sample in EMPTY:
  - Capture gray as the reference and load bin.
  - No step, no err.
  - Go to ACQUIRE with good_cnt=0.
- en=1 sample in ACQUIRE or LOCKED:
  - gray == reference: hold. No pulses, no state change, good_cnt unchanged.
  - gray == exp: legal step.
    - Update the reference and bin; step=1.
    - wrap=1 if the old bin was 2^WIDTH-1.
    - good_cnt increments, saturating at LOCK_N.
    - ACQUIRE moves to LOCKED when good_cnt reaches LOCK_N.
  - Anything else is an error: backward step, skip, multi-bit change.
    - err=1; err_cnt increments, saturating.
    - The reference and bin reload from gray.
    - good_cnt=0, go to ACQUIRE, locked drops.
- en=0: state, bin, good_cnt and err_cnt hold; step, wrap and err are 0.
- err and step are mutually exclusive. wrap implies step.
- locked = (state == LOCKED), registered.

## Timing

- Reset values: bin=0, step=0, wrap=0, err=0, locked=0, err_cnt=0, state EMPTY, good_cnt=0.
- Assertion of rst (low) takes effect immediately, not at the next edge. Release is synchronous in effect: the first edge with rst=1 is the first one that samples.
- Latency is one cycle. The outputs for a sample taken at edge N are valid after edge N and stay stable until edge N+1.
- Pulses last exactly one cycle per qualifying sample. Back-to-back legal steps give step high on consecutive cycles.
- locked rises in the same cycle as the step pulse that brings good_cnt to LOCK_N. It falls in the same cycle as err.
- Reset mid-LOCKED: all outputs clear. The first post-reset sample is treated as in EMPTY, so it is never flagged.

## Test plan

- Legal sequence:
  - Stimulus: reset, then en=1 with gray = 000,001,011,010,110,111,101,100,000.
  - Required: bin = 0..7,0; step on every sample after the first; wrap only on the 100→000 sample; locked rises on sample 110 (4th step); err_cnt=0.
- Hold and enable gaps:
  - Stimulus: 011 held for 3 edges, then en=0 for 2 edges while gray=010, then en=1.
  - Required: no pulses during the hold or the en=0 gap; bin stays 2; a single step when en returns, with bin=3.
- Illegal loop:
  - Stimulus: while LOCKED, feed 110,111,101,110.
  - Required: 101→110 gives err=1 (expected 100); err_cnt=1; locked=0; bin=4; the next legal 111 gives step with locked still 0.
- Skip and backward:
  - Stimulus: 001→010, then 010→011.
  - Required: err on both; err_cnt increments by 2; no step or wrap on either.
- Saturation:
  - Stimulus: ERR_W=2, six consecutive errors.
  - Required: err_cnt reads 1,2,3,3,3,3 and err pulses every time.
- Async reset:
  - Stimulus: assert rst low between edges while locked with bin=5; release; sample 010.
  - Required: all outputs 0 immediately, without waiting for an edge; after release, bin=3 with no step and no err; the state is ACQUIRE.
